// File: rtl/matrix_frame_scheduler.sv
// Double-buffered 8x8 RGB frame store with a two-requester round-robin write arbiter.
// Optional MATRIX_CLEAR_ON_SWAP_EN: after each swap the new back buffer is cleared over 8 cycles.
module matrix_frame_scheduler #(
    parameter logic [23:0] CLR_VALUE = 24'h000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid0,
    input  logic [2:0]       wr_row0,
    input  logic [23:0]      wr_data0,
    output logic             wr_ready0,
    input  logic             wr_valid1,
    input  logic [2:0]       wr_row1,
    input  logic [23:0]      wr_data1,
    output logic             wr_ready1,
    input  logic             commit,
    input  logic             frame_sync,
    output logic             commit_pending,
    output logic             swap_done,
    output logic [7:0][23:0] front_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
`ifdef MATRIX_CLEAR_ON_SWAP_EN
    localparam logic [1:0] CLEAR = 2'd2;
`endif

    logic [1:0]       state;
    logic             sel;
    logic             rr;
    logic [7:0][23:0] buf_a;
    logic [7:0][23:0] buf_b;
    logic             grant0;
    logic             grant1;
    logic             we;
    logic [2:0]       we_row;
    logic [23:0]      we_data;
`ifdef MATRIX_CLEAR_ON_SWAP_EN
    logic [2:0]       clr_row;
`endif

    // A lone requester always wins; on contention the rr pointer picks.
    always_comb begin
        grant0 = wr_valid0 && (!wr_valid1 || !rr);
        grant1 = wr_valid1 && (!wr_valid0 || rr);
    end

    assign wr_ready0      = (state == IDLE) && grant0;
    assign wr_ready1      = (state == IDLE) && grant1;
    assign commit_pending = (state == PEND);
    assign front_data     = sel ? buf_b : buf_a;

    always_comb begin
        we      = 1'b0;
        we_row  = 3'd0;
        we_data = 24'd0;
        if (wr_ready0) begin
            we      = 1'b1;
            we_row  = wr_row0;
            we_data = wr_data0;
        end else if (wr_ready1) begin
            we      = 1'b1;
            we_row  = wr_row1;
            we_data = wr_data1;
        end
`ifdef MATRIX_CLEAR_ON_SWAP_EN
        else if (state == CLEAR) begin
            we      = 1'b1;
            we_row  = clr_row;
            we_data = CLR_VALUE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            rr        <= 1'b0;
            swap_done <= 1'b0;
`ifdef MATRIX_CLEAR_ON_SWAP_EN
            clr_row   <= 3'd0;
`endif
        end else begin
            swap_done <= 1'b0;
            if (state == IDLE && wr_valid0 && wr_valid1) begin
                rr <= ~rr;
            end
            case (state)
                IDLE: begin
                    if (commit) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (frame_sync) begin
                        sel       <= ~sel;
                        swap_done <= 1'b1;
`ifdef MATRIX_CLEAR_ON_SWAP_EN
                        state     <= CLEAR;
                        clr_row   <= 3'd0;
`else
                        state     <= IDLE;
`endif
                    end
                end
`ifdef MATRIX_CLEAR_ON_SWAP_EN
                CLEAR: begin
                    clr_row <= clr_row + 3'd1;
                    if (clr_row == 3'd7) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // The back buffer is whichever one is not currently presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_a <= {8{CLR_VALUE}};
            buf_b <= {8{CLR_VALUE}};
        end else if (we) begin
            if (sel) begin
                buf_a[we_row] <= we_data;
            end else begin
                buf_b[we_row] <= we_data;
            end
        end
    end

endmodule

// File: doc/matrix_frame_scheduler.md
# matrix_frame_scheduler

Double-buffered frame store and write arbiter feeding the 8x8 RGB dot-matrix row driver. Two requesters (text renderer, effect/scroll engine) write 24-bit rows into a back buffer through a round-robin arbiter; a commit request swaps back and front buffers only at a frame boundary, so the driver never scans a torn frame. Sits between the pattern generators and the dot-matrix driver's 192-bit frame input.

## Interface
- CLR_VALUE, 24'h000000, row value loaded into buffers at reset (and on swap-clear, see Configuration)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- wr_valid0  in  1  requester 0 write request
- wr_row0  in  3  requester 0 target row
- wr_data0  in  24  requester 0 row data (R,G,B bytes MSB first)
- wr_ready0  out  1  requester 0 write accepted this edge when high with wr_valid0
- wr_valid1 / wr_row1 / wr_data1 / wr_ready1  same as requester 0
- commit  in  1  one-cycle pulse: present back buffer at next frame boundary
- frame_sync  in  1  one-cycle pulse from row scanner at end of row 7
- commit_pending  out  1  high while swap is waiting for frame_sync
- swap_done  out  1  one-cycle pulse, cycle after buffers swapped
- front_data  out  [7:0][23:0]  frame presented to the driver

## Operation
- Two 8x24 buffers A/B; sel register picks front; front_data = front buffer, registered storage, no combinational path from write ports.
- States: IDLE (writes accepted), PEND (commit latched, writes blocked), CLEAR (only with macro).
- Arbitration in IDLE: single valid requester is granted; both valid -> requester indicated by rr pointer granted, pointer then moves to the other requester. No valid -> pointer unchanged.
- wr_readyN = (state==IDLE) && grantN, combinational from valids, pointer, state. Exactly one write per cycle max.
- Accepted write: back[wr_rowN] <= wr_dataN at that edge. Requesters hold valid/row/data stable until ready.
- IDLE + commit -> PEND; commit_pending high from next cycle. A write accepted in the same cycle as commit lands in the back buffer before swap.
- PEND + frame_sync -> sel toggles at that edge, swap_done high next cycle, state -> IDLE (or CLEAR).
- Ignored events: commit in PEND or CLEAR; frame_sync in IDLE or CLEAR. commit and frame_sync same cycle in IDLE: enter PEND, swap waits for the following frame_sync.
- Without clear, new back buffer holds the previous front frame (stale content, requesters overwrite).

## Timing
- Reset (async assert): state IDLE, sel 0 (A front), rr pointer 0, both buffers all rows CLR_VALUE, wr_ready0/1 0 unless valid, commit_pending 0, swap_done 0, front_data = 8×CLR_VALUE. Reset mid-PEND discards the pending commit and all written data.
- Write latency to back buffer: 1 edge. Write-to-display latency: commit + next frame_sync + 1 cycle.
- front_data changes only on the edge consuming frame_sync in PEND; constant otherwise.
- commit pulse at edge N -> commit_pending high cycle N+1 through the cycle containing the consuming frame_sync edge F; low after F; swap_done high cycle F+1 only.

## Configuration
- MATRIX_CLEAR_ON_SWAP_EN defined: after swap, state CLEAR for 8 cycles writing CLR_VALUE to new back rows 0..7 in order, wr_ready0/1 low, commit ignored; then IDLE. Reset during CLEAR aborts to reset state.
- Undefined: no CLEAR state; swap returns directly to IDLE, back buffer keeps stale frame.

## Test plan
- Reset with CLR_VALUE=24'h000000 -> front_data all zero, commit_pending 0, readys 0 with no valids.
- Req0 writes row 3 = 24'hFF0000, commit, frame_sync 20 cycles later -> front_data[3]=24'hFF0000 on cycle after sync edge, swap_done single pulse, other rows 0.
- Both requesters valid continuously for 4 cycles, rows 0..3 -> grants alternate 0,1,0,1 starting from pointer 0; each write lands once.
- commit then writes held valid in PEND -> ready stays 0 until swap; frame_sync in IDLE before commit -> no swap, front_data unchanged.
- Macro on: swap then check wr_ready low exactly 8 cycles, new back buffer all CLR_VALUE; macro off: new back buffer equals old front frame.
- Reset asserted while PEND -> commit_pending 0 immediately, later frame_sync causes no swap.
